// File: rtl/hilo_muldiv.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit producing one combined HI/LO register-file write.
// Latency: start accepted in cycle T, write/done pulse in T+33, next start accepted at T+34.
// Backpressure: stall_o holds the issuing stage from acceptance until the write cycle; flush_i aborts.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               done_o,
  output logic               hilo_we_o,
  output logic [1:0]         hilo_waddr_o,
  output logic [2*WIDTH-1:0] hilo_wdata_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         op_q;
  logic               neg_res_q;   // operand signs differ: negate product / quotient
  logic               neg_rem_q;   // dividend was negative: remainder takes its sign
  logic [WIDTH-1:0]   a_q;         // |multiplicand| (unused by divide once loaded)
  logic [WIDTH-1:0]   b_q;         // |divisor| (multiplier lives in acc_q low half)
  logic [2*WIDTH-1:0] acc_q;       // MUL: {partial hi, shifting multiplier}; DIV: {rem, quot}

  logic               accept;
  logic               last_iter;
  logic               op_signed;
  logic               sgn1, sgn2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   res_lo, res_hi;

  assign accept       = (state_q == S_IDLE) && start_i && !flush_i;
  assign last_iter    = (cnt_q == CW'(WIDTH - 1));
  assign hilo_waddr_o = 2'b01;

  // Operand magnitudes and sign flags for the incoming request (signed ops are MULT and DIV).
  always_comb begin
    op_signed = !op_i[0];
    sgn1      = op_signed && src1_i[WIDTH-1];
    sgn2      = op_signed && src2_i[WIDTH-1];
    mag1      = sgn1 ? -src1_i : src1_i;
    mag2      = sgn2 ? -src2_i : src2_i;
  end

  // One iteration of shift-add multiply and restoring divide on the magnitude registers.
  always_comb begin
    // Add multiplicand if the current multiplier LSB is set, then shift the whole thing right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    // Trial subtract from the left-shifted remainder (33 bits wide before the subtract).
    div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, b_q};
    if (div_trial[WIDTH+1]) begin
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; FINISH never stalls so the pipeline advances with the write.
  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    hilo_we_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = start_i && !flush_i;
        if (accept) state_d = S_BUSY;
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (flush_i)        state_d = S_IDLE;
        else if (last_iter) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_o    = !flush_i;
        hilo_we_o = !flush_i;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: capture operands on acceptance, iterate while busy, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      op_q      <= op_i;
      neg_res_q <= sgn1 ^ sgn2;
      neg_rem_q <= sgn1;
      a_q       <= mag1;
      b_q       <= mag2;
      acc_q     <= {{WIDTH{1'b0}}, (op_i[1] ? mag1 : mag2)};
    end else if (state_q == S_BUSY) begin
      cnt_q     <= cnt_q + CW'(1);
      acc_q     <= op_q[1] ? div_next : mul_next;
    end
  end

  // Sign fix-up of the magnitude result; {LO, HI} packing for the write port.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    if (op_q[1]) begin
      // Divide by zero leaves rem = |dividend|; re-applying the dividend sign restores src1
      // bit-for-bit, so HI already equals the raw dividend. Only LO needs overriding.
      res_lo = (b_q == '0) ? '1 : quot_fix;
      res_hi = rem_fix;
    end
    hilo_wdata_o = {res_lo, res_hi};
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: directed corner cases plus random ops against an arithmetic model.
// Latency: every operation is checked for exact cycle timing of stall/write/done.
// Backpressure: flush in IDLE/BUSY/FINISH, start held through FINISH and async reset are exercised.
module tb_hilo_muldiv;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic        hilo_we_o;
  logic [1:0]  hilo_waddr_o;
  logic [63:0] hilo_wdata_o;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .op_i         (op_i),
    .src1_i       (src1_i),
    .src2_i       (src2_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .hilo_we_o    (hilo_we_o),
    .hilo_waddr_o (hilo_waddr_o),
    .hilo_wdata_o (hilo_wdata_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {LO, HI} straight from the architectural definition of each op.
  function automatic logic [63:0] ref_hilo(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa, sb;
    int          ia, ib;
    logic [63:0] p;
    logic [31:0] lo, hi;
    lo = '0;
    hi = '0;
    case (op)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        lo = p[31:0];
        hi = p[63:32];
      end
      2'b01: begin
        p  = {32'd0, a} * {32'd0, b};
        lo = p[31:0];
        hi = p[63:32];
      end
      default: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'd0;
        end else if (op == 2'b10) begin
          ia = a;
          ib = b;
          lo = 32'(ia / ib);
          hi = 32'(ia % ib);
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
    return {lo, hi};
  endfunction

  // Present a request at a negedge (cycle T) and check the combinational stall.
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    start_i = 1'b1;
    flush_i = 1'b0;
    #1;
    chk({tag, " stall_issue"}, 64'(stall_o), 64'd1);
  endtask

  // Walk cycles T+1..T+33 and check the busy window, then the write cycle.
  // keep=1 leaves start_i high with a new request presented; otherwise inputs are scrambled.
  task automatic finish_op(input string tag, input logic [63:0] exp, input logic keep,
                           input logic [1:0] nop, input logic [31:0] na, input logic [31:0] nb);
    int good;
    good = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (keep) begin
        op_i   = nop;
        src1_i = na;
        src2_i = nb;
      end else begin
        start_i = 1'b0;
        op_i    = 2'($urandom);
        src1_i  = $urandom;
        src2_i  = $urandom;
      end
      #1;
      if (stall_o === 1'b1 && hilo_we_o === 1'b0 && done_o === 1'b0) good++;
    end
    chk({tag, " busy_window"}, 64'(good), 64'd32);
    @(negedge clk);
    #1;
    chk({tag, " stall_finish"}, 64'(stall_o), 64'd0);
    chk({tag, " we_done"}, 64'({hilo_we_o, done_o}), 64'b11);
    chk({tag, " wdata"}, hilo_wdata_o, exp);
    if (!keep) begin
      @(negedge clk);
      #1;
      chk({tag, " idle_after"}, 64'({stall_o, hilo_we_o, done_o}), 64'd0);
    end
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          seen;

    rst     = 1'b1;
    start_i = 1'b0;
    op_i    = 2'b00;
    src1_i  = '0;
    src2_i  = '0;
    flush_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset ctl", 64'({stall_o, done_o, hilo_we_o}), 64'd0);
    chk("reset waddr", 64'(hilo_waddr_o), 64'd1);
    chk("reset wdata", hilo_wdata_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic corners, expected values written out by hand.
    issue("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
    finish_op("mult_neg3x5", {32'hFFFF_FFF1, 32'hFFFF_FFFF}, 1'b0, 2'b00, 0, 0);
    issue("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", {32'h0000_0001, 32'hFFFF_FFFE}, 1'b0, 2'b00, 0, 0);
    issue("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000);
    finish_op("mult_minsq", {32'h0000_0000, 32'h4000_0000}, 1'b0, 2'b00, 0, 0);
    issue("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_m7_2", {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 1'b0, 2'b00, 0, 0);
    issue("divu_7_0", 2'b11, 32'd7, 32'd0);
    finish_op("divu_7_0", {32'hFFFF_FFFF, 32'd7}, 1'b0, 2'b00, 0, 0);
    issue("div_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0);
    finish_op("div_m7_0", {32'hFFFF_FFFF, 32'hFFFF_FFF9}, 1'b0, 2'b00, 0, 0);
    issue("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", {32'h8000_0000, 32'd0}, 1'b0, 2'b00, 0, 0);

    // start_i held through FINISH: ignored there, re-accepted in IDLE the next cycle.
    issue("b2b_first", 2'b11, 32'd100, 32'd7);
    finish_op("b2b_first", {32'd14, 32'd2}, 1'b1, 2'b00, 32'd7, 32'hFFFF_FFFA);
    @(negedge clk);
    #1;
    chk("b2b refire_stall", 64'(stall_o), 64'd1);
    finish_op("b2b_second", {32'hFFFF_FFD6, 32'hFFFF_FFFF}, 1'b0, 2'b00, 0, 0);

    // Flush mid-BUSY at T+10, new MULTU 3x4 at T+12 writes at T+45; no write in between.
    issue("flush_busy", 2'b00, $urandom, $urandom);
    seen = 0;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (k == 1)  start_i = 1'b0;
      if (k == 10) flush_i = 1'b1;
      if (k == 11) flush_i = 1'b0;
      if (k == 12) begin
        op_i    = 2'b01;
        src1_i  = 32'd3;
        src2_i  = 32'd4;
        start_i = 1'b1;
      end
      if (k == 13) start_i = 1'b0;
      #1;
      if (k == 11) chk("flush_busy stall_drop", 64'(stall_o), 64'd0);
      if (k == 12) chk("flush_busy restart_stall", 64'(stall_o), 64'd1);
      if (hilo_we_o !== 1'b0 || done_o !== 1'b0) seen++;
    end
    chk("flush_busy no_write", 64'(seen), 64'd0);
    @(negedge clk);
    #1;
    chk("flush_busy restart we_done", 64'({hilo_we_o, done_o}), 64'b11);
    chk("flush_busy restart wdata", hilo_wdata_o, {32'd12, 32'd0});

    // Flush in FINISH masks the write combinationally.
    issue("flush_fin", 2'b11, 32'd100, 32'd7);
    repeat (32) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush_fin mask", 64'({hilo_we_o, done_o}), 64'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_fin idle", 64'({stall_o, hilo_we_o, done_o}), 64'd0);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    start_i = 1'b1;
    flush_i = 1'b1;
    #1;
    chk("flush_idle stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("flush_idle not_busy", 64'(stall_o), 64'd0);

    // Asynchronous reset mid-BUSY, then a normal operation.
    issue("rst_busy", 2'b01, $urandom, $urandom);
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_busy ctl", 64'({stall_o, done_o, hilo_we_o}), 64'd0);
    chk("rst_busy wdata", hilo_wdata_o, 64'd0);
    chk("rst_busy waddr", 64'(hilo_waddr_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy idle", 64'({stall_o, done_o, hilo_we_o}), 64'd0);
    issue("post_rst", 2'b01, 32'd3, 32'd4);
    finish_op("post_rst", {32'd12, 32'd0}, 1'b0, 2'b00, 0, 0);

    // Random operations against the arithmetic model, biased toward corner operands.
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      issue("rand", op, a, b);
      finish_op("rand", ref_hilo(op, a, b), 1'b0, 2'b00, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
